pdm_speaker: RTL and testbench

- Transmit-side counterpart of the PDM microphone path: converts signed PCM audio samples into a 1-bit PDM stream plus bit clock for a PDM amplifier or speaker.
- Samples enter through a valid/ready handshake into a small FIFO.
- The FIFO is drained at the audio sample rate.
- A first-order sigma-delta modulator produces one PDM bit per bit-clock period.
- Sits between the audio mixer/sequencer and the board speaker pins.

---
 rtl/pdm_speaker.sv | 141 ++++++++++++++
 tb/tb_pdm_speaker.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_speaker.sv
// PCM-to-PDM transmit path: sample FIFO drained at the audio rate feeding a
// first-order sigma-delta modulator clocked by a divided 50% duty bit clock.
module pdm_speaker #(
    parameter int unsigned SAMPLE_DEPTH     = 16,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned INPUT_FREQUENCY  = 12000000,
    parameter int unsigned PDM_FREQUENCY    = 1000000,
    parameter int unsigned SAMPLE_FREQUENCY = 8000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLE_DEPTH-1:0]       audio,
    input  logic                          audio_valid,
    output logic                          audio_ready,
    input  logic                          mute,
    output logic                          pdm_clk,
    output logic                          pdm_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);

    localparam int unsigned N      = SAMPLE_DEPTH;
    localparam int unsigned DIV    = INPUT_FREQUENCY / PDM_FREQUENCY;
    localparam int unsigned SDIV   = PDM_FREQUENCY / SAMPLE_FREQUENCY;
    localparam int unsigned DIV_W  = $clog2(DIV);
    localparam int unsigned SDIV_W = (SDIV > 1) ? $clog2(SDIV) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(DIV / 2);
    localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(SDIV - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
    localparam logic [N-1:0]      MID_SCALE = {1'b1, {(N-1){1'b0}}};

    logic [DIV_W-1:0]  bit_div_q,  bit_div_d;
    logic [SDIV_W-1:0] samp_div_q, samp_div_d;
    logic [N-1:0]      acc_q,      acc_d;
    logic [N-1:0]      cur_q,      cur_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]  level_q,    level_d;
    logic              pdm_q,      pdm_d;
    logic              underrun_q, underrun_d;
    logic [N-1:0]      mem_q [FIFO_DEPTH];

    logic              step_c;
    logic              load_c;
    logic              empty_c;
    logic              full_c;
    logic              push_c;
    logic              pop_c;
    logic [N-1:0]      u_c;
    logic [N:0]        sum_c;

    // Event decode from registered state; step is the last high cycle of pdm_clk.
    always_comb begin
        step_c  = (bit_div_q == DIV_HALF);
        load_c  = step_c && (samp_div_q == '0);
        empty_c = (level_q == '0);
        full_c  = (level_q == LVL_FULL);
        push_c  = audio_valid && !full_c;
        pop_c   = load_c && !empty_c;
        u_c     = mute ? MID_SCALE : {~cur_q[N-1], cur_q[N-2:0]};
        sum_c   = {1'b0, acc_q} + {1'b0, u_c};
    end

    always_comb begin
        bit_div_d  = (bit_div_q == '0) ? DIV_LAST : bit_div_q - DIV_W'(1);
        samp_div_d = samp_div_q;
        acc_d      = acc_q;
        pdm_d      = pdm_q;
        cur_d      = cur_q;
        underrun_d = 1'b0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;

        if (step_c) begin
            samp_div_d = (samp_div_q == '0) ? SDIV_LAST : samp_div_q - SDIV_W'(1);
            acc_d      = sum_c[N-1:0];
            pdm_d      = sum_c[N];
        end

        // A load with an empty FIFO keeps the old sample; a same-cycle push lands after.
        if (load_c && empty_c) begin
            underrun_d = 1'b1;
        end
        if (pop_c) begin
            cur_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_div_q  <= DIV_LAST;
            samp_div_q <= SDIV_LAST;
            acc_q      <= '0;
            cur_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pdm_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            bit_div_q  <= bit_div_d;
            samp_div_q <= samp_div_d;
            acc_q      <= acc_d;
            cur_q      <= cur_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pdm_q      <= pdm_d;
            underrun_q <= underrun_d;
        end
    end

    // Sample storage carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (rst && push_c) begin
            mem_q[wr_ptr_q] <= audio;
        end
    end

    assign audio_ready = !full_c;
    assign pdm_clk     = (bit_div_q >= DIV_HALF);
    assign pdm_data    = pdm_q;
    assign fifo_level  = level_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_pdm_speaker.sv
// Randomized bench for pdm_speaker: an arithmetic reference model feeds
// expected-bit and expected-underrun queues that a negedge monitor drains.
module tb_pdm_speaker;

    localparam int DEPTH = 4;
    localparam int DIV   = 12;
    localparam int SDIV  = 125;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] audio;
    logic        audio_valid;
    logic        audio_ready;
    logic        mute;
    logic        pdm_clk;
    logic        pdm_data;
    logic [2:0]  fifo_level;
    logic        underrun;

    pdm_speaker dut (
        .clk         (clk),
        .rst         (rst),
        .audio       (audio),
        .audio_valid (audio_valid),
        .audio_ready (audio_ready),
        .mute        (mute),
        .pdm_clk     (pdm_clk),
        .pdm_data    (pdm_data),
        .fifo_level  (fifo_level),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int unsigned m_acc;
    int          m_cur;
    int          m_fifo[$];
    int          cyc;
    int          steps;
    bit          started = 1'b0;
    bit          exp_bits[$];
    int          exp_under[$];

    // Monitor state
    bit          cur_exp;
    bit          prev_clk;
    bit          act_bits[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: bit period DIV cycles from reset, one modulator step per period,
    // a sample load every SDIV steps; loads see the FIFO before a same-edge push.
    always @(posedge clk) begin : model
        int unsigned u;
        int unsigned s;
        bit          can_push;
        if (!rst) begin
            m_acc = 0;
            m_cur = 0;
            m_fifo.delete();
            exp_bits.delete();
            exp_under.delete();
            cyc     = 0;
            steps   = 0;
            started = 1'b1;
        end else if (started) begin
            can_push = (m_fifo.size() < DEPTH);
            if ((cyc % DIV) == DIV / 2 - 1) begin
                u = mute ? 32768 : unsigned'(m_cur + 32768);
                s = m_acc + u;
                exp_bits.push_back(s >= 65536);
                m_acc = s % 65536;
                steps++;
                if ((steps % SDIV) == 0) begin
                    if (m_fifo.size() == 0) exp_under.push_back(cyc + 1);
                    else                    m_cur = m_fifo.pop_front();
                end
            end
            if (audio_valid && can_push) m_fifo.push_back(int'($signed(audio)));
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (cyc == 0) begin
                cur_exp  = 1'b0;
                prev_clk = 1'b1;
                act_bits.delete();
            end
            check("pdm_clk", int'(pdm_clk), int'((cyc % DIV) < DIV / 2));
            check("fifo_level", int'(fifo_level), m_fifo.size());
            check("audio_ready", int'(audio_ready), int'(m_fifo.size() != DEPTH));
            if (prev_clk && !pdm_clk) begin
                if (exp_bits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pdm_step: falling edge with no expected bit (cycle %0d)", cyc);
                end else begin
                    cur_exp = exp_bits.pop_front();
                end
                act_bits.push_back(pdm_data);
            end
            check("pdm_data", int'(pdm_data), int'(cur_exp));
            prev_clk = pdm_clk;
            while (exp_under.size() > 0 && exp_under[0] < cyc) begin
                checks++;
                errors++;
                $display("FAIL underrun_missing: got 0 expected pulse at cycle %0d", exp_under[0]);
                void'(exp_under.pop_front());
            end
            if (underrun) begin
                if (exp_under.size() > 0 && exp_under[0] == cyc) begin
                    checks++;
                    void'(exp_under.pop_front());
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL underrun_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                end
            end
        end
    end

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // Offers one sample; while the FIFO is full, junk with valid=1 must be ignored.
    task automatic push(input logic [15:0] v);
        int n = 0;
        @(negedge clk);
        while (!audio_ready && n < 4000) begin
            audio_valid = 1'b1;
            audio       = 16'($urandom);
            @(negedge clk);
            n++;
        end
        if (!audio_ready) begin
            audio_valid = 1'b0;
            timeout("push");
        end else begin
            audio       = v;
            audio_valid = 1'b1;
            @(negedge clk);
            audio_valid = 1'b0;
        end
    endtask

    task automatic burst5();
        logic [15:0] vals [5];
        int n;
        for (int i = 0; i < 5; i++) vals[i] = 16'($urandom);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                check("burst_ready_full", int'(audio_ready), 0);
                check("burst_level_full", int'(fifo_level), 4);
            end
            n = 0;
            while (!audio_ready && n < 4000) begin
                audio_valid = 1'b1;
                audio       = 16'($urandom);
                @(negedge clk);
                n++;
            end
            if (!audio_ready) begin
                timeout("burst_push");
            end else begin
                audio       = vals[i];
                audio_valid = 1'b1;
                @(negedge clk);
            end
        end
        audio_valid = 1'b0;
    endtask

    task automatic wait_underrun();
        int n = 0;
        @(negedge clk);
        while (!underrun && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!underrun) timeout("wait_underrun");
    endtask

    task automatic wait_level0();
        int n = 0;
        @(negedge clk);
        while (fifo_level != 3'd0 && n < 8000) begin
            @(negedge clk);
            n++;
        end
        if (fifo_level != 3'd0) timeout("wait_level0");
    endtask

    task automatic wait_bits(input int cnt);
        int n = 0;
        while (act_bits.size() < cnt && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (act_bits.size() < cnt) timeout("wait_bits");
    endtask

    // Mid-scale sample 0 after reset gives 0,1,0,1.
    task automatic check_reset_pattern(input string name);
        bit exp4 [4];
        exp4 = '{1'b0, 1'b1, 1'b0, 1'b1};
        wait_bits(4);
        if (act_bits.size() >= 4) begin
            for (int i = 0; i < 4; i++) check(name, int'(act_bits[i]), int'(exp4[i]));
        end
    endtask

    initial begin
        int idx;
        int ones;
        rst         = 1'b0;
        audio       = '0;
        audio_valid = 1'b0;
        mute        = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        check_reset_pattern("powerup_bit");
        repeat (1600) @(negedge clk);

        push(16'h4000);
        repeat (1700) @(negedge clk);

        push(16'h8000);
        push(16'h7FFF);
        wait_level0();
        idx = act_bits.size();
        wait_bits(idx + 202);
        ones = 0;
        for (int i = idx + 2; i < idx + 202 && i < act_bits.size(); i++) ones += int'(act_bits[i]);
        check("max_sample_ones", ones, 200);

        wait_underrun();
        burst5();
        wait_level0();

        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(50, 1800)) @(negedge clk);
            mute = ($urandom_range(0, 3) == 0);
            push(16'($urandom));
            if ($urandom_range(0, 2) == 0) push(16'($urandom));
        end
        mute = 1'b0;

        wait_level0();
        wait_underrun();
        push(16'($urandom));
        push(16'($urandom));
        push(16'($urandom));
        check("pre_reset_level", int'(fifo_level), 3);
        rst = 1'b0;
        @(negedge clk);
        check("reset_level", int'(fifo_level), 0);
        check("reset_pdm_data", int'(pdm_data), 0);
        check("reset_pdm_clk", int'(pdm_clk), 1);
        check("reset_ready", int'(audio_ready), 1);
        rst = 1'b1;
        check_reset_pattern("midreset_bit");
        repeat (200) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
